// File: rtl/lookup_cfg_writer.sv
// Lookup-stage config writer: assembles TCAM key/mask entries and action-RAM words from
// AXI-Stream config beats and issues single-cycle write strobes to the lookup engine.
module lookup_cfg_writer #(
    parameter int DATA_W = 32,
    parameter int KEY_W  = 1024,
    parameter int ACT_W  = 25,
    parameter int ADDR_W = 4,
    parameter int STAGE  = 0
) (
    input  logic              axis_clk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    input  logic              s_axis_tlast,
    output logic              s_axis_tready,
    output logic [KEY_W-1:0]  lookup_din,
    output logic [KEY_W-1:0]  lookup_din_mask,
    output logic [ADDR_W-1:0] lookup_din_addr,
    output logic              lookup_din_en,
    output logic [ACT_W-1:0]  action_data_in,
    output logic [ADDR_W-1:0] action_addr,
    output logic              action_en,
    output logic [7:0]        cfg_err_cnt
);
    // state | meaning
    // HDR   | waiting for a header beat
    // KEY   | collecting NW key beats, LSW first
    // MASK  | collecting NW mask beats, LSW first
    // ACT   | collecting the single action beat
    // WRITE | strobe cycle; input stalled
    // DRAIN | discarding beats up to and including tlast

    localparam int NW    = KEY_W / DATA_W;
    localparam int CNT_W = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NW - 1);
    localparam logic [3:0]       STAGE_ID = 4'(STAGE);

    typedef enum logic [2:0] {
        S_HDR   = 3'd0,
        S_KEY   = 3'd1,
        S_MASK  = 3'd2,
        S_ACT   = 3'd3,
        S_WRITE = 3'd4,
        S_DRAIN = 3'd5
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              beat;
    logic              err_inc;
    logic [3:0]        hdr_stage;
    logic [3:0]        hdr_type;

    // Held low during reset so no beat is lost to a register that cannot take it.
    assign s_axis_tready = ~aresetn && (state != S_WRITE);
    assign beat          = s_axis_tvalid && s_axis_tready;
    assign hdr_stage     = s_axis_tdata[DATA_W-1 -: 4];
    assign hdr_type      = s_axis_tdata[DATA_W-5 -: 4];

    // Each error path leaves the packet (to HDR or DRAIN), so one packet counts at most once.
    always_comb begin
        err_inc = 1'b0;
        if (beat) begin
            case (state)
                S_HDR:   err_inc = s_axis_tlast ||
                                   ((hdr_stage == STAGE_ID) && (hdr_type > 4'd1));
                S_KEY:   err_inc = s_axis_tlast;
                S_MASK:  err_inc = (cnt == CNT_LAST) ? ~s_axis_tlast : s_axis_tlast;
                S_ACT:   err_inc = ~s_axis_tlast;
                default: err_inc = 1'b0;
            endcase
        end
    end

    always_ff @(posedge axis_clk or posedge aresetn) begin
        if (aresetn) begin
            cfg_err_cnt <= 8'd0;
        end else if (err_inc && (cfg_err_cnt != 8'hFF)) begin
            cfg_err_cnt <= cfg_err_cnt + 8'd1;
        end
    end

    always_ff @(posedge axis_clk or posedge aresetn) begin
        if (aresetn) begin
            state           <= S_HDR;
            cnt             <= '0;
            addr_q          <= '0;
            lookup_din      <= '0;
            lookup_din_mask <= '0;
            lookup_din_addr <= '0;
            lookup_din_en   <= 1'b0;
            action_data_in  <= '0;
            action_addr     <= '0;
            action_en       <= 1'b0;
        end else begin
            lookup_din_en <= 1'b0;
            action_en     <= 1'b0;
            case (state)
                S_HDR: begin
                    if (beat) begin
                        addr_q <= s_axis_tdata[ADDR_W-1:0];
                        cnt    <= '0;
                        if (s_axis_tlast) begin
                            state <= S_HDR;
                        end else if (hdr_stage != STAGE_ID) begin
                            state <= S_DRAIN;
                        end else if (hdr_type == 4'd0) begin
                            state <= S_KEY;
                        end else if (hdr_type == 4'd1) begin
                            state <= S_ACT;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_KEY: begin
                    if (beat) begin
                        lookup_din[int'(cnt) * DATA_W +: DATA_W] <= s_axis_tdata;
                        if (s_axis_tlast) begin
                            state <= S_HDR;
                        end else if (cnt == CNT_LAST) begin
                            cnt   <= '0;
                            state <= S_MASK;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_MASK: begin
                    if (beat) begin
                        lookup_din_mask[int'(cnt) * DATA_W +: DATA_W] <= s_axis_tdata;
                        if (cnt == CNT_LAST) begin
                            cnt <= '0;
                            if (s_axis_tlast) begin
                                lookup_din_en   <= 1'b1;
                                lookup_din_addr <= addr_q;
                                state           <= S_WRITE;
                            end else begin
                                state <= S_DRAIN;
                            end
                        end else if (s_axis_tlast) begin
                            state <= S_HDR;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_ACT: begin
                    if (beat) begin
                        action_data_in <= s_axis_tdata[ACT_W-1:0];
                        if (s_axis_tlast) begin
                            action_en   <= 1'b1;
                            action_addr <= addr_q;
                            state       <= S_WRITE;
                        end else begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_WRITE: begin
                    state <= S_HDR;
                end
                S_DRAIN: begin
                    if (beat && s_axis_tlast) begin
                        state <= S_HDR;
                    end
                end
                default: begin
                    state <= S_HDR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lookup_cfg_writer.sv
// Bench for lookup_cfg_writer: packet-level reference model feeding a strobe scoreboard.
module tb_lookup_cfg_writer;
    localparam int DATA_W = 32;
    localparam int KEY_W  = 1024;
    localparam int ACT_W  = 25;
    localparam int ADDR_W = 4;
    localparam int STAGE  = 0;
    localparam int NW     = KEY_W / DATA_W;

    logic              axis_clk = 1'b0;
    logic              aresetn  = 1'b1;
    logic [DATA_W-1:0] s_axis_tdata = '0;
    logic              s_axis_tvalid = 1'b0;
    logic              s_axis_tlast = 1'b0;
    logic              s_axis_tready;
    logic [KEY_W-1:0]  lookup_din;
    logic [KEY_W-1:0]  lookup_din_mask;
    logic [ADDR_W-1:0] lookup_din_addr;
    logic              lookup_din_en;
    logic [ACT_W-1:0]  action_data_in;
    logic [ADDR_W-1:0] action_addr;
    logic              action_en;
    logic [7:0]        cfg_err_cnt;

    always #5 axis_clk = ~axis_clk;

    lookup_cfg_writer #(
        .DATA_W(DATA_W), .KEY_W(KEY_W), .ACT_W(ACT_W), .ADDR_W(ADDR_W), .STAGE(STAGE)
    ) dut (
        .axis_clk(axis_clk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .lookup_din(lookup_din), .lookup_din_mask(lookup_din_mask),
        .lookup_din_addr(lookup_din_addr), .lookup_din_en(lookup_din_en),
        .action_data_in(action_data_in), .action_addr(action_addr),
        .action_en(action_en), .cfg_err_cnt(cfg_err_cnt)
    );

    typedef struct {
        bit                is_tcam;
        logic [ADDR_W-1:0] addr;
        logic [KEY_W-1:0]  key;
        logic [KEY_W-1:0]  mask;
        logic [ACT_W-1:0]  act;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          checks = 0;
    int          failures = 0;
    int          exp_err = 0;
    int          n_tcam = 0;
    int          n_act = 0;
    bit          mon_en = 1'b0;
    logic [31:0] pkt[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endfunction

    function automatic void chk_wide(string name, logic [KEY_W-1:0] act, logic [KEY_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            for (int i = 0; i < NW; i++) begin
                if (act[i*DATA_W +: DATA_W] !== exp[i*DATA_W +: DATA_W]) begin
                    $display("FAIL %s word %0d actual=0x%h expected=0x%h", name, i,
                             act[i*DATA_W +: DATA_W], exp[i*DATA_W +: DATA_W]);
                    break;
                end
            end
        end
    endfunction

    // Packet-level model: a packet is everything up to tlast; outcome follows from
    // header fields and length alone.
    function automatic void model_pkt(input logic [31:0] b[$]);
        int          len;
        logic [31:0] hdr;
        logic [31:0] w;
        logic [3:0]  st;
        logic [3:0]  ty;
        bit          err;
        exp_t        e;
        len = b.size();
        hdr = b[0];
        st  = hdr[31:28];
        ty  = hdr[27:24];
        err = 1'b0;
        e.addr = hdr[ADDR_W-1:0];
        e.key  = '0;
        e.mask = '0;
        e.act  = '0;
        if (len == 1) begin
            err = 1'b1;
        end else if (st != 4'(STAGE)) begin
            err = 1'b0;
        end else if (ty == 4'd0) begin
            if (len == 1 + 2 * NW) begin
                e.is_tcam = 1'b1;
                for (int i = 0; i < NW; i++) begin
                    e.key[i*DATA_W +: DATA_W]  = b[1 + i];
                    e.mask[i*DATA_W +: DATA_W] = b[1 + NW + i];
                end
                exp_q.push_back(e);
            end else begin
                err = 1'b1;
            end
        end else if (ty == 4'd1) begin
            if (len == 2) begin
                w = b[1];
                e.is_tcam = 1'b0;
                e.act = w[ACT_W-1:0];
                exp_q.push_back(e);
            end else begin
                err = 1'b1;
            end
        end else begin
            err = 1'b1;
        end
        if (err && exp_err < 255) exp_err++;
    endfunction

    always @(negedge axis_clk) begin
        if (mon_en && !aresetn) begin
            chk("tready_low_only_in_write", s_axis_tready, !(lookup_din_en || action_en));
            chk("single_strobe", lookup_din_en && action_en, 1'b0);
            if (lookup_din_en || action_en) begin
                if (lookup_din_en) n_tcam++;
                if (action_en) n_act++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_strobe actual=lookup_en:%0b action_en:%0b expected=none",
                             lookup_din_en, action_en);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("strobe_kind_tcam", lookup_din_en, mon_e.is_tcam);
                    if (mon_e.is_tcam) begin
                        chk("tcam_addr", lookup_din_addr, mon_e.addr);
                        chk_wide("tcam_key", lookup_din, mon_e.key);
                        chk_wide("tcam_mask", lookup_din_mask, mon_e.mask);
                    end else begin
                        chk("act_addr", action_addr, mon_e.addr);
                        chk("act_data", action_data_in, mon_e.act);
                    end
                end
            end
        end
    end

    task automatic send_pkt(input logic [31:0] b[$], input int gap_pct, input bit term);
        bit acc;
        int n;
        for (int i = 0; i < b.size(); i++) begin
            while ($urandom_range(99) < gap_pct) begin
                s_axis_tvalid = 1'b0;
                @(posedge axis_clk); #1;
            end
            s_axis_tdata  = b[i];
            s_axis_tlast  = term && (i == b.size() - 1);
            s_axis_tvalid = 1'b1;
            acc = 1'b0;
            n   = 0;
            while (!acc) begin
                @(negedge axis_clk);
                acc = s_axis_tready;
                @(posedge axis_clk); #1;
                n++;
                if (!acc && n > 50) begin
                    $display("FAIL beat_accept_timeout actual=tready_low_%0d_cycles expected=accept", n);
                    $fatal(1, "stalled");
                end
            end
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic finish_pkt(string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge axis_clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_strobe_missing actual_pending=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge axis_clk);
        @(negedge axis_clk);
        chk({name, "_err_cnt"}, cfg_err_cnt, exp_err);
        @(posedge axis_clk); #1;
    endtask

    task automatic build_tcam(input logic [3:0] st, input logic [3:0] addr, input bit rnd);
        pkt.delete();
        pkt.push_back({st, 4'd0, 20'($urandom), addr});
        for (int i = 0; i < NW; i++) pkt.push_back(rnd ? 32'($urandom) : 32'h1000 + 32'(i));
        for (int i = 0; i < NW; i++) pkt.push_back(rnd ? 32'($urandom) : 32'hFFFF_FFFF);
    endtask

    task automatic check_reset_outputs(string name);
        chk_wide({name, "_rst_din"}, lookup_din, '0);
        chk_wide({name, "_rst_mask"}, lookup_din_mask, '0);
        chk({name, "_rst_din_addr"}, lookup_din_addr, 0);
        chk({name, "_rst_din_en"}, lookup_din_en, 0);
        chk({name, "_rst_act_data"}, action_data_in, 0);
        chk({name, "_rst_act_addr"}, action_addr, 0);
        chk({name, "_rst_act_en"}, action_en, 0);
        chk({name, "_rst_err"}, cfg_err_cnt, 0);
        chk({name, "_rst_tready"}, s_axis_tready, 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          kind;
        int          len;
        int          t_before;
        logic [3:0]  st;
        logic [31:0] w;

        repeat (2) @(negedge axis_clk);
        check_reset_outputs("init");
        @(posedge axis_clk); #1;
        aresetn = 1'b0;
        mon_en  = 1'b1;
        repeat (2) @(posedge axis_clk); #1;

        // Case 1: canonical TCAM write
        build_tcam(4'(STAGE), 4'd3, 1'b0);
        pkt[0] = 32'h0000_0003;
        model_pkt(pkt);
        send_pkt(pkt, 0, 1'b1);
        finish_pkt("c1");
        chk("c1_key_lsw", lookup_din[31:0], 32'h1000);
        chk("c1_key_msw", lookup_din[1023:992], 32'h101F);
        chk("c1_mask_ones", &lookup_din_mask, 1'b1);
        chk("c1_addr", lookup_din_addr, 4'd3);
        chk("c1_tcam_pulses", n_tcam, 1);

        // Case 2: action write; TCAM outputs must hold
        pkt = '{32'h0100_0007, 32'h0155_AAAA};
        model_pkt(pkt);
        send_pkt(pkt, 0, 1'b1);
        finish_pkt("c2");
        chk("c2_act_data", action_data_in, 25'h155_AAAA);
        chk("c2_act_addr", action_addr, 4'd7);
        chk("c2_counts", {n_tcam[15:0], n_act[15:0]}, {16'd1, 16'd1});
        chk("c2_key_held", lookup_din[31:0], 32'h1000);

        // Case 3: other stage drained silently
        pkt = '{32'h1100_0002, 32'h1234_5678};
        model_pkt(pkt);
        send_pkt(pkt, 0, 1'b1);
        finish_pkt("c3");
        chk("c3_no_err", cfg_err_cnt, 0);

        // Case 4: TCAM truncated after 10 key beats, then a good action
        pkt.delete();
        pkt.push_back(32'h0000_0005);
        for (int i = 0; i < 10; i++) pkt.push_back(32'hABC0_0000 + 32'(i));
        model_pkt(pkt);
        send_pkt(pkt, 0, 1'b1);
        finish_pkt("c4");
        chk("c4_err_one", cfg_err_cnt, 1);
        t_before = n_tcam;
        pkt = '{32'h0100_000A, 32'h00AB_CDEF};
        model_pkt(pkt);
        send_pkt(pkt, 0, 1'b1);
        finish_pkt("c4b");
        chk("c4_no_tcam_strobe", n_tcam, t_before);
        chk("c4b_act_data", action_data_in, 25'h0AB_CDEF);

        // Case 5: case 1 with 50% valid gaps
        build_tcam(4'(STAGE), 4'd3, 1'b0);
        pkt[0] = 32'h0000_0003;
        model_pkt(pkt);
        send_pkt(pkt, 50, 1'b1);
        finish_pkt("c5");
        chk("c5_key_msw", lookup_din[1023:992], 32'h101F);

        // Randomised mix of good and malformed packets
        for (int p = 0; p < 40; p++) begin
            kind = $urandom_range(6);
            st   = ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'(STAGE);
            case (kind)
                0, 1: build_tcam(st, 4'($urandom), 1'b1);
                2: pkt = '{{st, 4'd1, 20'($urandom), 4'($urandom)}, 32'($urandom)};
                3: begin
                    build_tcam(st, 4'($urandom), 1'b1);
                    len = 2 + $urandom_range(2 * NW - 2);
                    while (pkt.size() > len) void'(pkt.pop_back());
                end
                4: begin
                    if ($urandom_range(1) == 0) begin
                        build_tcam(st, 4'($urandom), 1'b1);
                    end else begin
                        pkt = '{{st, 4'd1, 20'($urandom), 4'($urandom)}, 32'($urandom)};
                    end
                    len = 1 + $urandom_range(3);
                    for (int i = 0; i < len; i++) pkt.push_back(32'($urandom));
                end
                5: begin
                    pkt = '{{st, 4'(2 + $urandom_range(13)), 20'($urandom), 4'($urandom)}};
                    len = 1 + $urandom_range(3);
                    for (int i = 0; i < len; i++) pkt.push_back(32'($urandom));
                end
                default: pkt = '{{st, 4'($urandom), 20'($urandom), 4'($urandom)}};
            endcase
            model_pkt(pkt);
            send_pkt(pkt, $urandom_range(60), 1'b1);
            finish_pkt("rand");
        end

        // Error counter saturation with header-only packets
        for (int p = 0; p < 260; p++) begin
            w = 32'($urandom);
            pkt = '{w};
            model_pkt(pkt);
            send_pkt(pkt, 0, 1'b1);
        end
        finish_pkt("sat");
        chk("sat_255", cfg_err_cnt, 8'hFF);

        // Case 6: reset mid-MASK, then an action packet
        build_tcam(4'(STAGE), 4'd9, 1'b1);
        while (pkt.size() > 1 + NW + 5) void'(pkt.pop_back());
        send_pkt(pkt, 0, 1'b0);
        #2;
        aresetn = 1'b1;
        exp_err = 0;
        @(negedge axis_clk);
        check_reset_outputs("c6");
        @(posedge axis_clk); #1;
        aresetn = 1'b0;
        t_before = n_tcam;
        pkt = '{32'h0100_0007, 32'h0155_AAAA};
        model_pkt(pkt);
        send_pkt(pkt, 0, 1'b1);
        finish_pkt("c6");
        chk("c6_no_tcam_strobe", n_tcam, t_before);
        chk_wide("c6_key_cleared", lookup_din, '0);
        chk("c6_act_data", action_data_in, 25'h155_AAAA);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
